// File: rtl/sweep_freq_meter.sv
// Hysteresis edge counter / frequency meter for the swept-waveform loopback.
// Optional per-window peak-to-peak tracking is enabled with `define FREQ_METER_PEAK_EN.
module sweep_freq_meter #(
  parameter int DATA_W      = 8,
  parameter int MID         = 128,
  parameter int HYST        = 16,
  parameter int GATE_CYCLES = 50_000_000,
  parameter int CNT_W       = 16
) (
  input  logic              clk_wave,
  input  logic              sys_rst,
  input  logic              en,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic [CNT_W-1:0]  freq_out,
  output logic              freq_valid,
  output logic              freq_ovf,
  output logic [DATA_W-1:0] vpp_out
);

  localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [DATA_W-1:0] HI_TH     = DATA_W'(MID + HYST);
  localparam logic [DATA_W-1:0] LO_TH     = DATA_W'(MID - HYST);
  localparam logic [GW-1:0]     GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {UNK, LOW, HIGH} lvl_t;

  lvl_t             lvl;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             ovf;

  logic             is_hi, is_lo, rise, terminal, sat;
  logic [CNT_W-1:0] edge_nxt;
  logic             ovf_nxt;

  // Next-count values include an edge detected this cycle, so the terminal
  // cycle can report it without a one-cycle hole.
  always_comb begin
    is_hi    = adc_valid && (adc_data >= HI_TH);
    is_lo    = adc_valid && (adc_data <= LO_TH);
    rise     = en && is_hi && (lvl == LOW);
    terminal = en && (gate_cnt == GATE_LAST);
    sat      = (edge_cnt == CNT_MAX);
    edge_nxt = (rise && !sat) ? edge_cnt + 1'b1 : edge_cnt;
    ovf_nxt  = ovf | (rise & sat);
  end

  // Level detector; in-band samples never move it, leaving UNK never counts.
  always_ff @(posedge clk_wave or posedge sys_rst) begin
    if (sys_rst)     lvl <= UNK;
    else if (!en)    lvl <= UNK;
    else if (is_hi)  lvl <= HIGH;
    else if (is_lo)  lvl <= LOW;
  end

  always_ff @(posedge clk_wave or posedge sys_rst) begin
    if (sys_rst) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf      <= 1'b0;
    end else if (!en || terminal) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      gate_cnt <= gate_cnt + 1'b1;
      edge_cnt <= edge_nxt;
      ovf      <= ovf_nxt;
    end
  end

  // Report registers hold across en-low so the last result stays visible.
  always_ff @(posedge clk_wave or posedge sys_rst) begin
    if (sys_rst) begin
      freq_out   <= '0;
      freq_ovf   <= 1'b0;
      freq_valid <= 1'b0;
    end else begin
      freq_valid <= terminal;
      if (terminal) begin
        freq_out <= edge_nxt;
        freq_ovf <= ovf_nxt;
      end
    end
  end

`ifdef FREQ_METER_PEAK_EN
  logic [DATA_W-1:0] pk_min, pk_max, min_nxt, max_nxt;
  logic              seen, seen_nxt;

  always_comb begin
    min_nxt  = (adc_valid && adc_data < pk_min) ? adc_data : pk_min;
    max_nxt  = (adc_valid && adc_data > pk_max) ? adc_data : pk_max;
    seen_nxt = seen | adc_valid;
  end

  always_ff @(posedge clk_wave or posedge sys_rst) begin
    if (sys_rst) begin
      pk_min <= '1;
      pk_max <= '0;
      seen   <= 1'b0;
    end else if (!en || terminal) begin
      pk_min <= '1;
      pk_max <= '0;
      seen   <= 1'b0;
    end else begin
      pk_min <= min_nxt;
      pk_max <= max_nxt;
      seen   <= seen_nxt;
    end
  end

  always_ff @(posedge clk_wave or posedge sys_rst) begin
    if (sys_rst)       vpp_out <= '0;
    else if (terminal) vpp_out <= seen_nxt ? (max_nxt - min_nxt) : '0;
  end
`else
  assign vpp_out = '0;
`endif

endmodule

// File: tb/tb_sweep_freq_meter.sv
// Randomised + directed bench for sweep_freq_meter against a window-level model.
module tb_sweep_freq_meter;
  localparam int DATA_W = 8;
  localparam int MID    = 128;
  localparam int HYST   = 16;
  localparam int G      = 100;
  localparam int CNT_W  = 5;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk_wave = 1'b0;
  logic              sys_rst  = 1'b0;
  logic              en       = 1'b0;
  logic [DATA_W-1:0] adc_data = '0;
  logic              adc_valid = 1'b0;
  logic [CNT_W-1:0]  freq_out;
  logic              freq_valid;
  logic              freq_ovf;
  logic [DATA_W-1:0] vpp_out;

  sweep_freq_meter #(
    .DATA_W(DATA_W), .MID(MID), .HYST(HYST), .GATE_CYCLES(G), .CNT_W(CNT_W)
  ) dut (
    .clk_wave(clk_wave), .sys_rst(sys_rst), .en(en), .adc_data(adc_data),
    .adc_valid(adc_valid), .freq_out(freq_out), .freq_valid(freq_valid),
    .freq_ovf(freq_ovf), .vpp_out(vpp_out)
  );

  always #5 clk_wave = ~clk_wave;

  int checks = 0;
  int failures = 0;
  int mode = 0;
  int vmode = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Waveform driver: new sample every falling edge
  initial begin
    int ph = 0;
    int k;
    forever begin
      @(negedge clk_wave);
      ph++;
      case (mode)
        0: adc_data = (ph % 20 < 10) ? 8'd255 : 8'd0;
        1: begin k = ph % 32; adc_data = 8'(120 + ((k < 16) ? k : 32 - k)); end
        2: adc_data = (ph % 2 == 1) ? 8'd140 : 8'd118;
        3: adc_data = (ph % 10 < 5) ? 8'd150 : 8'd100;
        4: adc_data = (ph % 2 == 1) ? 8'd255 : 8'd0;
        5: adc_data = 8'd0;
        6: begin k = ph % 42; adc_data = 8'(20 + 10 * ((k <= 21) ? k : 42 - k)); end
        default: adc_data = 8'($urandom_range(0, 255));
      endcase
      case (vmode)
        0: adc_valid = 1'b1;
        1: adc_valid = 1'($urandom % 2);
        default: adc_valid = 1'b0;
      endcase
    end
  end

  // Window-level reference: unbounded edge tally, saturated only when reported
  initial begin
    int m_gate = 0, m_edges = 0, m_lvl = 0, m_mn = 255, m_mx = 0, d;
    bit m_seen = 0;
    int e_freq = 0, e_ovf = 0, e_vpp = 0, e_valid = 0;
    forever begin
      @(posedge clk_wave);
      if (sys_rst || !en) begin
        m_gate = 0; m_edges = 0; m_lvl = 0; m_mn = 255; m_mx = 0; m_seen = 0;
        e_valid = 0;
        if (sys_rst) begin e_freq = 0; e_ovf = 0; e_vpp = 0; end
      end else begin
        if (adc_valid) begin
          d = int'(adc_data);
          if (d >= MID + HYST) begin
            if (m_lvl == 1) m_edges++;
            m_lvl = 2;
          end else if (d <= MID - HYST) m_lvl = 1;
          if (d < m_mn) m_mn = d;
          if (d > m_mx) m_mx = d;
          m_seen = 1;
        end
        if (m_gate == G - 1) begin
          e_valid = 1;
          e_freq  = (m_edges > CMAX) ? CMAX : m_edges;
          e_ovf   = (m_edges > CMAX) ? 1 : 0;
`ifdef FREQ_METER_PEAK_EN
          e_vpp   = m_seen ? m_mx - m_mn : 0;
`else
          e_vpp   = 0;
`endif
          m_gate = 0; m_edges = 0; m_mn = 255; m_mx = 0; m_seen = 0;
        end else begin
          e_valid = 0;
          m_gate++;
        end
      end
      @(negedge clk_wave);
      if (!sys_rst) begin
        check("freq_valid", int'(freq_valid), e_valid);
        check("freq_out",   int'(freq_out),   e_freq);
        check("freq_ovf",   int'(freq_ovf),   e_ovf);
        check("vpp_out",    int'(vpp_out),    e_vpp);
      end
    end
  end

  task automatic wait_report(output int f, output int o, output int v);
    int n = 0;
    do begin @(negedge clk_wave); n++; end while (!freq_valid && n < 3 * G);
    if (!freq_valid) begin
      checks++; failures++;
      $display("FAIL report_timeout: got no freq_valid expected one within %0d cycles", 3 * G);
    end
    f = int'(freq_out); o = int'(freq_ovf); v = int'(vpp_out);
  endtask

  task automatic settle_report(input int md, input int vm, output int f, output int o, output int v);
    mode = md; vmode = vm;
    wait_report(f, o, v);
    wait_report(f, o, v);
  endtask

  initial begin
    int f, o, v, lat;
    bit seen_pulse;
    #1 sys_rst = 1'b1;
    #1;
    check("rst_freq_out", int'(freq_out), 0);
    check("rst_valid", int'(freq_valid), 0);
    check("rst_ovf", int'(freq_ovf), 0);
    check("rst_vpp", int'(vpp_out), 0);
    repeat (3) @(negedge clk_wave);
    sys_rst = 1'b0;
    @(negedge clk_wave);
    en = 1'b1;

    wait_report(f, o, v);
    check("sq20_first_in_4_5", int'(f >= 4 && f <= 5), 1);
    wait_report(f, o, v);
    check("sq20_freq", f, 5);
    check("sq20_ovf", o, 0);

    settle_report(1, 0, f, o, v);
    check("band_tri_freq", f, 0);
    settle_report(2, 0, f, o, v);
    check("noise_freq", f, 0);
    settle_report(3, 0, f, o, v);
    check("p10_freq", f, 10);
    settle_report(4, 0, f, o, v);
    check("p2_sat_freq", f, CMAX);
    check("p2_sat_ovf", o, 1);
    mode = 5;
    wait_report(f, o, v);
    wait_report(f, o, v);
    check("low_freq", f, 0);
    check("low_ovf", o, 0);

    settle_report(6, 0, f, o, v);
`ifdef FREQ_METER_PEAK_EN
    check("peak_vpp", v, 210);
`else
    check("peak_vpp_off", v, 0);
`endif
    settle_report(6, 2, f, o, v);
    check("novalid_vpp", v, 0);
    check("novalid_freq", f, 0);

    // Abort a window mid-way and time the restart
    settle_report(3, 0, f, o, v);
    repeat (50) @(negedge clk_wave);
    en = 1'b0;
    seen_pulse = 0;
    repeat (10) begin @(negedge clk_wave); if (freq_valid) seen_pulse = 1; end
    check("abort_no_valid", int'(seen_pulse), 0);
    en = 1'b1;
    lat = 0;
    do begin @(negedge clk_wave); lat++; end while (!freq_valid && lat < 3 * G);
    check("restart_latency", lat, G);

    // Random data, sparse valid, random en drops
    mode = 7; vmode = 1;
    repeat (8) begin
      repeat ($urandom_range(20, 250)) @(negedge clk_wave);
      if ($urandom % 3 == 0) begin
        en = 1'b0;
        repeat ($urandom_range(1, 12)) @(negedge clk_wave);
        en = 1'b1;
      end
    end

    settle_report(3, 0, f, o, v);
    check("pre_rst_freq", f, 10);
    repeat (37) @(negedge clk_wave);
    #2 sys_rst = 1'b1;
    #1;
    check("midrst_freq_out", int'(freq_out), 0);
    check("midrst_valid", int'(freq_valid), 0);
    check("midrst_ovf", int'(freq_ovf), 0);
    check("midrst_vpp", int'(vpp_out), 0);
    @(negedge clk_wave);
    sys_rst = 1'b0;
    wait_report(f, o, v);
    wait_report(f, o, v);
    check("post_rst_freq", f, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
